// File: rtl/instr_fetch_pkg.sv
// Shared ISA constants for the fetch path: NOP encoding, jump-target field, default PC width.
package instr_fetch_pkg;
  localparam int          PC_WIDTH_DEFAULT = 13;
  localparam int          INSTR_WIDTH      = 14;
  localparam logic [13:0] ISA_NOP          = 14'h0000;
  localparam int          JMP_FIELD_MSB    = 10;
  localparam int          JMP_FIELD_W      = JMP_FIELD_MSB + 1;
endpackage

// File: rtl/instr_fetch_return_stack.sv
// Circular hardware return stack; pointer wraps silently, overflow/underflow flags
// only when INSTR_FETCH_STACK_ERR_EN is defined.
module instr_fetch_return_stack #(
  parameter int WIDTH = 13,
  parameter int DEPTH = 8,
  parameter int PTR_W = $clog2(DEPTH)
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             push,
  input  logic             pop,
  input  logic [WIDTH-1:0] din,
  output logic [WIDTH-1:0] dout
`ifdef INSTR_FETCH_STACK_ERR_EN
  ,
  output logic             stack_ovf,
  output logic             stack_unf
`endif
);

  logic [WIDTH-1:0] r_mem [DEPTH];
  logic [PTR_W-1:0] r_sp;
  logic [PTR_W-1:0] w_top;

  assign w_top = r_sp - PTR_W'(1);
  assign dout  = r_mem[w_top];

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_sp <= '0;
      for (int i = 0; i < DEPTH; i++) r_mem[i] <= '0;
    end else if (push) begin
      r_mem[r_sp] <= din;
      r_sp        <= r_sp + PTR_W'(1);
    end else if (pop) begin
      r_sp <= w_top;
    end
  end

`ifdef INSTR_FETCH_STACK_ERR_EN
  // Occupancy saturates; the pointer itself keeps wrapping.
  logic [PTR_W:0] r_cnt;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_cnt     <= '0;
      stack_ovf <= 1'b0;
      stack_unf <= 1'b0;
    end else if (push) begin
      if (r_cnt == (PTR_W+1)'(DEPTH)) stack_ovf <= 1'b1;
      else                            r_cnt     <= r_cnt + (PTR_W+1)'(1);
    end else if (pop) begin
      if (r_cnt == '0) stack_unf <= 1'b1;
      else             r_cnt     <= r_cnt - (PTR_W+1)'(1);
    end
  end
`endif

endmodule

// File: rtl/instr_fetch.sv
// Fetch/PC block: owns PC, instruction register and return stack; prefetch model (PC = next word).
// Optional macro INSTR_FETCH_STACK_ERR_EN adds sticky stack_ovf/stack_unf outputs.
module instr_fetch
  import instr_fetch_pkg::*;
#(
  parameter int                  PC_WIDTH     = PC_WIDTH_DEFAULT,
  parameter int                  STACK_DEPTH  = 8,
  parameter logic [PC_WIDTH-1:0] RESET_VECTOR = '0
) (
  input  logic                   clk,
  input  logic                   rst,
  input  logic                   instr_rd_en,
  input  logic                   instr_flush,
  input  logic                   pc_incr_en,
  input  logic                   pc_j_en,
  input  logic                   stack_push,
  input  logic                   stack_pop,
  input  logic [PC_WIDTH-12:0]   pclath_hi,
  output logic [PC_WIDTH-1:0]    pmem_addr,
  input  logic [INSTR_WIDTH-1:0] pmem_data,
  output logic [INSTR_WIDTH-1:0] instr_current,
  output logic [PC_WIDTH-1:0]    pc
`ifdef INSTR_FETCH_STACK_ERR_EN
  ,
  output logic                   stack_ovf,
  output logic                   stack_unf
`endif
);

  logic [PC_WIDTH-1:0]    r_pc;
  logic [INSTR_WIDTH-1:0] r_ir;
  logic [PC_WIDTH-1:0]    w_jmp_target;
  logic [PC_WIDTH-1:0]    w_stack_top;
  logic                   w_push;
  logic                   w_pop;

  // Push only rides on a jump; a jump also masks any pop on the same edge.
  assign w_push       = stack_push & pc_j_en;
  assign w_pop        = stack_pop & ~pc_j_en;
  assign w_jmp_target = {pclath_hi, r_ir[JMP_FIELD_MSB:0]};

  instr_fetch_return_stack #(
    .WIDTH (PC_WIDTH),
    .DEPTH (STACK_DEPTH)
  ) u_stack (
    .clk       (clk),
    .rst       (rst),
    .push      (w_push),
    .pop       (w_pop),
    .din       (r_pc),
    .dout      (w_stack_top)
`ifdef INSTR_FETCH_STACK_ERR_EN
    ,
    .stack_ovf (stack_ovf),
    .stack_unf (stack_unf)
`endif
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_ir <= ISA_NOP;
    end else if (instr_flush) begin
      r_ir <= ISA_NOP;
    end else if (instr_rd_en) begin
      r_ir <= pmem_data;
    end
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_pc <= RESET_VECTOR;
    end else if (pc_j_en) begin
      r_pc <= w_jmp_target;
    end else if (stack_pop) begin
      r_pc <= w_stack_top;
    end else if (pc_incr_en) begin
      r_pc <= r_pc + PC_WIDTH'(1);
    end
  end

  assign pc            = r_pc;
  assign pmem_addr     = r_pc;
  assign instr_current = r_ir;

endmodule

// File: tb/tb_instr_fetch.sv
// Directed bench for instr_fetch with a scoreboard of expected PC/IR values per step.
module tb_instr_fetch;

  logic        clk;
  logic        rst;
  logic        instr_rd_en, instr_flush, pc_incr_en, pc_j_en, stack_push, stack_pop;
  logic [1:0]  pclath_hi;
  logic [12:0] pmem_addr;
  logic [13:0] pmem_data;
  logic [13:0] instr_current;
  logic [12:0] pc;
`ifdef INSTR_FETCH_STACK_ERR_EN
  logic        stack_ovf, stack_unf;
`endif

  logic [13:0] pmem [8192];
  assign pmem_data = pmem[pmem_addr];

  int n_cmp  = 0;
  int n_fail = 0;

  logic [12:0] exp_pc_q [$];
  logic [13:0] exp_ir_q [$];
  string       tag_q    [$];

  instr_fetch dut (
    .clk           (clk),
    .rst           (rst),
    .instr_rd_en   (instr_rd_en),
    .instr_flush   (instr_flush),
    .pc_incr_en    (pc_incr_en),
    .pc_j_en       (pc_j_en),
    .stack_push    (stack_push),
    .stack_pop     (stack_pop),
    .pclath_hi     (pclath_hi),
    .pmem_addr     (pmem_addr),
    .pmem_data     (pmem_data),
    .instr_current (instr_current),
    .pc            (pc)
`ifdef INSTR_FETCH_STACK_ERR_EN
    ,
    .stack_ovf     (stack_ovf),
    .stack_unf     (stack_unf)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  initial begin
    #200000;
    $display("FAIL watchdog: run did not finish, got timeout want completion");
    $fatal(1, "watchdog");
  end

  task automatic expect_state(input string tag, input logic [12:0] epc, input logic [13:0] eir);
    exp_pc_q.push_back(epc);
    exp_ir_q.push_back(eir);
    tag_q.push_back(tag);
  endtask

  task automatic check_out();
    logic [12:0] epc;
    logic [13:0] eir;
    string       tag;
    epc = exp_pc_q.pop_front();
    eir = exp_ir_q.pop_front();
    tag = tag_q.pop_front();
    n_cmp++;
    assert (pc === epc) else begin
      n_fail++;
      $error("FAIL %s pc: got %h want %h", tag, pc, epc);
    end
    n_cmp++;
    assert (pmem_addr === epc) else begin
      n_fail++;
      $error("FAIL %s pmem_addr: got %h want %h", tag, pmem_addr, epc);
    end
    n_cmp++;
    assert (instr_current === eir) else begin
      n_fail++;
      $error("FAIL %s instr_current: got %h want %h", tag, instr_current, eir);
    end
  endtask

  task automatic check_bit(input string tag, input logic got, input logic want);
    n_cmp++;
    assert (got === want) else begin
      n_fail++;
      $error("FAIL %s: got %b want %b", tag, got, want);
    end
  endtask

  // Drive one cycle of strobes, record the expectation, sample 1 time unit after the edge.
  task automatic cyc(input string tag, input logic rd, input logic fl, input logic inc,
                     input logic j, input logic pu, input logic po, input logic [1:0] ph,
                     input logic [12:0] epc, input logic [13:0] eir);
    instr_rd_en = rd; instr_flush = fl; pc_incr_en = inc;
    pc_j_en = j; stack_push = pu; stack_pop = po; pclath_hi = ph;
    expect_state(tag, epc, eir);
    @(posedge clk);
    #1;
    check_out();
    instr_rd_en = 0; instr_flush = 0; pc_incr_en = 0;
    pc_j_en = 0; stack_push = 0; stack_pop = 0; pclath_hi = 2'b00;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    @(posedge clk);
    #1;
    rst = 1'b0;
  endtask

  initial begin
    for (int i = 0; i < 8192; i++) pmem[i] = 14'h0000;
    rst = 1'b1;
    instr_rd_en = 0; instr_flush = 0; pc_incr_en = 0;
    pc_j_en = 0; stack_push = 0; stack_pop = 0; pclath_hi = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    expect_state("reset_state", 13'h0000, 14'h0000);
    check_out();
`ifdef INSTR_FETCH_STACK_ERR_EN
    check_bit("reset_ovf", stack_ovf, 1'b0);
    check_bit("reset_unf", stack_unf, 1'b0);
`endif
    rst = 1'b0;

    // Reach pc=0x123, then assert reset between edges.
    pmem[0] = 14'h0123;
    cyc("ld_0123", 1, 0, 0, 0, 0, 0, 2'b00, 13'h0000, 14'h0123);
    cyc("jmp_0123", 0, 0, 0, 1, 0, 0, 2'b00, 13'h0123, 14'h0123);
    #3;
    rst = 1'b1;
    #1;
    expect_state("async_reset", 13'h0000, 14'h0000);
    check_out();
    @(posedge clk);
    #1;
    rst = 1'b0;

    // Linear fetch and PC wrap.
    pmem[0] = 14'h3005;
    pmem[1] = 14'h07FF;
    cyc("fetch_rd_incr", 1, 0, 1, 0, 0, 0, 2'b00, 13'h0001, 14'h3005);
    cyc("ld_07ff", 1, 0, 0, 0, 0, 0, 2'b00, 13'h0001, 14'h07FF);
    cyc("jmp_1fff", 0, 0, 0, 1, 0, 0, 2'b11, 13'h1FFF, 14'h07FF);
    cyc("pc_wrap", 0, 0, 1, 0, 0, 0, 2'b00, 13'h0000, 14'h07FF);

    // Skip: reach pc=5 via jump on 0x3005.
    cyc("ld_3005", 1, 0, 0, 0, 0, 0, 2'b00, 13'h0000, 14'h3005);
    cyc("jmp_5", 0, 0, 0, 1, 0, 0, 2'b00, 13'h0005, 14'h3005);
    cyc("skip_flush_incr", 0, 1, 1, 0, 0, 0, 2'b00, 13'h0006, 14'h0000);
    pmem[6] = 14'h2A34;
    cyc("flush_over_rd", 1, 1, 0, 0, 0, 0, 2'b00, 13'h0006, 14'h0000);
    cyc("hold", 0, 0, 0, 0, 0, 0, 2'b01, 13'h0006, 14'h0000);

    // GOTO.
    cyc("ld_2a34", 1, 0, 0, 0, 0, 0, 2'b00, 13'h0006, 14'h2A34);
    cyc("goto", 0, 1, 0, 1, 0, 0, 2'b01, 13'h0A34, 14'h0000);

    // CALL / RETURN from pc=0x10; push alone must be ignored.
    pmem[13'h0A34] = 14'h0010;
    pmem[13'h0010] = 14'h2100;
    cyc("ld_0010", 1, 0, 0, 0, 0, 0, 2'b00, 13'h0A34, 14'h0010);
    cyc("push_alone", 0, 0, 0, 0, 1, 0, 2'b00, 13'h0A34, 14'h0010);
    cyc("jmp_0010", 0, 0, 0, 1, 0, 0, 2'b00, 13'h0010, 14'h0010);
    cyc("ld_2100", 1, 0, 0, 0, 0, 0, 2'b00, 13'h0010, 14'h2100);
    cyc("call", 0, 0, 0, 1, 1, 0, 2'b00, 13'h0100, 14'h2100);
    cyc("return", 0, 1, 0, 0, 0, 1, 2'b00, 13'h0010, 14'h0000);

    // Stack wrap: clean reset, pc=1, then nine CALLs from pc=1..9.
    do_reset();
    for (int k = 0; k <= 9; k++) pmem[k] = 14'(k + 1);
    cyc("wrap_ld1", 1, 0, 0, 0, 0, 0, 2'b00, 13'h0000, 14'h0001);
    cyc("wrap_jmp1", 0, 0, 0, 1, 0, 0, 2'b00, 13'h0001, 14'h0001);
    for (int k = 1; k <= 9; k++) begin
      cyc($sformatf("wrap_ld%0d", k + 1), 1, 0, 0, 0, 0, 0, 2'b00, 13'(k), 14'(k + 1));
`ifdef INSTR_FETCH_STACK_ERR_EN
      if (k == 9) check_bit("ovf_before_push9", stack_ovf, 1'b0);
`endif
      cyc($sformatf("wrap_push%0d", k), 0, 0, 0, 1, 1, 0, 2'b00, 13'(k + 1), 14'(k + 1));
    end
`ifdef INSTR_FETCH_STACK_ERR_EN
    check_bit("ovf_after_push9", stack_ovf, 1'b1);
`endif
    for (int k = 9; k >= 2; k--) begin
      cyc($sformatf("wrap_pop_ret%0d", k), 0, 1, 0, 0, 0, 1, 2'b00, 13'(k), 14'h0000);
    end
`ifdef INSTR_FETCH_STACK_ERR_EN
    check_bit("unf_before_extra_pop", stack_unf, 1'b0);
`endif
    // Pointer wrapped to 1, so one more pop lands on slot 0 (holds 9).
    cyc("pop_empty", 0, 1, 0, 0, 0, 1, 2'b00, 13'h0009, 14'h0000);
`ifdef INSTR_FETCH_STACK_ERR_EN
    check_bit("unf_after_extra_pop", stack_unf, 1'b1);
    check_bit("ovf_sticky", stack_ovf, 1'b1);
`endif

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule

// File: doc/instr_fetch.md
Name: instr_fetch

Overview:
- Fetch and program-counter block. It is the responder to the control strobes issued by instruction_decoder: instr_rd_en, instr_flush, pc_incr_en and pc_j_en.
- Owns the PC, the instruction register (instr_current) driven into the decoder, and an 8-level hardware return stack for CALL/RETURN.
- Sits between program memory and instruction_decoder.

Parameters:
- PC_WIDTH, 13, program counter width.
- STACK_DEPTH, 8, return-stack entries; must be a power of two.
- RESET_VECTOR, 13'h0000, PC value after reset.

Ports:
- clk  in  1  system clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- instr_rd_en  in  1  load instr_current from program memory.
- instr_flush  in  1  load NOP (14'h0000) into instr_current.
- pc_incr_en  in  1  PC <= PC+1.
- pc_j_en  in  1  PC <= jump target.
- stack_push  in  1  push the pre-jump PC; qualifies pc_j_en (CALL).
- stack_pop  in  1  PC <= top of stack (RETURN/RETLW/RETFIE).
- pclath_hi  in  PC_WIDTH-11  upper jump-target bits from PCLATH<4:3>.
- pmem_addr  out  PC_WIDTH  program memory address; always equals PC.
- pmem_data  in  14  program memory word at pmem_addr; combinational read.
- instr_current  out  14  instruction register to the decoder.
- pc  out  PC_WIDTH  current PC, for PCL readback.

Behaviour:
- Reset (async, any cycle, including mid-instruction):
  - pc = RESET_VECTOR; instr_current = 14'h0000 (NOP); stack pointer = 0; all stack entries = 0.
  - Effect: the first decoder quad executes a NOP, and its q3 fetches from RESET_VECTOR.
- Invariant: PC always addresses the instruction after the one in instr_current (prefetch model).
- Instruction register update, per rising edge:
  - instr_flush=1: instr_current <= 14'h0000. Flush overrides instr_rd_en.
  - else instr_rd_en=1: instr_current <= pmem_data.
  - else: hold.
- PC update, priority high to low:
  1. pc_j_en: PC <= {pclath_hi, instr_current[10:0]}. The jump target is taken from the current instruction register value before any same-edge IR update.
  2. stack_pop: PC <= stack[sp-1]; sp <= sp-1.
  3. pc_incr_en: PC <= PC+1, modulo 2^PC_WIDTH. 13'h1FFF wraps to 13'h0000.
  4. none: hold.
- stack_push is honoured only together with pc_j_en.
  - On push: stack[sp] <= PC (old PC, i.e. the return address); sp <= sp+1.
  - stack_push without pc_j_en is ignored.
- Simultaneous stack_push and stack_pop: push wins, pop ignored (pc_j_en has priority).
- Stack is circular. The pointer wraps modulo STACK_DEPTH:
  - A ninth push overwrites the oldest entry.
  - A pop from empty returns whatever the wrapped entry holds.
  - Both are silent, matching PIC16F behaviour.
- Latency:
  - All updates take effect on the edge where the strobe is sampled.
  - pmem_addr follows pc combinationally, so read data is valid in the same cycle.
- Sequences driven by instruction_decoder:
  - Normal instruction (q3: rd+incr): fetches the next word.
  - Skip (q3: flush+incr): the skipped word is replaced by a NOP and PC advances past it.
  - GOTO (q3: flush+j): a NOP is executed, then the target is fetched on the NOP's q3.
  - CALL: flush+j+push.
  - RETURN: flush+pop.

Optional Feature:
- Macro: INSTR_FETCH_STACK_ERR_EN.
- Defined:
  - Adds output stack_ovf, 1 bit. Sticky; set on a push while the stack holds STACK_DEPTH entries.
  - Adds output stack_unf, 1 bit. Sticky; set on a pop while the stack holds 0 entries.
  - Occupancy is tracked by an extra count register of width clog2(STACK_DEPTH)+1, saturating at 0 and STACK_DEPTH.
  - Both flags are cleared only by rst.
  - Wrap behaviour of the stack itself is unchanged.
- Undefined: the ports and the count register are absent.

Decomposition:
- Shared package (isa.vh): isa_nop encoding (14'h0000) and the jump-target field position [10:0].
- New constant in isa.vh: pc_width_default = 13.
- One sub-module, return_stack (push, pop, din, dout, pointer, optional error counters), instantiated once.

Test Plan:
1. Reset: assert rst mid-cycle with pc=13'h0123 -> pc=0 and instr_current=0 immediately, without waiting for a clock edge.
2. Linear fetch: pmem[0]=14'h3005, rd+incr pulse -> instr_current=14'h3005, pc=1. Pulse at pc=13'h1FFF -> pc=0.
3. Skip: pc=5, flush+incr -> instr_current=0, pc=6. Flush+rd together -> instr_current=0.
4. GOTO: instr_current=14'h2A34, pclath_hi=2'b01, flush+j -> pc=13'h0A34, instr_current=0.
5. CALL/RETURN: pc=13'h0010, instr_current=14'h2100, j+push -> pc=13'h0100. Then flush+pop -> pc=13'h0010.
6. Stack wrap: 9 pushes with pc=1..9, then 8 pops -> returns 9,8,7,6,5,4,3,2. With INSTR_FETCH_STACK_ERR_EN defined, stack_ovf=1 after push 9; a further pop from empty sets stack_unf=1.
